// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge detector bank.
// Contents:
//   edge_mode_t        per-channel edge qualification mode
//   filter_cnt_width   stability counter width for a given filter length
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  // Counter must hold 0..cycles-1; never narrower than one bit.
  function automatic int unsigned filter_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_filter_channel.sv
// One edge detector channel: synchroniser, debounce filter, edge
// qualification and sticky pending flag (plus overrun flag when the
// build defines EDGE_OVERRUN_EN).
// Ports:
//   clk         system clock, posedge
//   rst         synchronous reset, active-high
//   signal      raw asynchronous input
//   mode        edge_mode_t, sampled at the filtered change event
//   clear       one-cycle strobe clearing pending (and overrun)
//   level       filtered, synchronised level
//   edge_pulse  one-cycle pulse per qualified edge
//   pending     sticky event flag
//   overrun     sticky flag: event arrived while pending (EDGE_OVERRUN_EN)
module edge_filter_channel
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal,
  input  edge_mode_t mode,
  input  logic       clear,
  output logic       level,
  output logic       edge_pulse,
  output logic       pending
`ifdef EDGE_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam int unsigned CW = filter_cnt_width(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync_out_c;
  logic                   differs_c;
  logic                   change_c;
  logic                   rise_ok_c;
  logic                   fall_ok_c;
  logic                   pulse_next_c;

  assign sync_out_c = sync_q[SYNC_STAGES-1];

  // Change event fires on the FILTER_CYCLES-th consecutive differing sample.
  always_comb begin
    differs_c    = (sync_out_c != level);
    change_c     = differs_c && (cnt == CW'(FILTER_CYCLES - 1));
    rise_ok_c    = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    fall_ok_c    = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    pulse_next_c = change_c && ((sync_out_c && rise_ok_c) || (!sync_out_c && fall_ok_c));
  end

  // Synchroniser shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
    end
  end

  // Stability counter and filtered level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= RESET_LEVEL;
    end else if (!differs_c) begin
      cnt <= '0;
    end else if (change_c) begin
      cnt   <= '0;
      level <= sync_out_c;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Pulse and sticky pending; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_pulse <= 1'b0;
      pending    <= 1'b0;
    end else begin
      edge_pulse <= pulse_next_c;
      pending    <= pulse_next_c | (pending & ~clear);
    end
  end

`ifdef EDGE_OVERRUN_EN
  // Overrun only when the prior event was neither consumed nor being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= (pulse_next_c & pending & ~clear) | (overrun & ~clear);
    end
  end
`endif

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector for UART asynchronous/control inputs with
// an aggregated, registered interrupt. Optional per-channel overrun
// flags are built when EDGE_OVERRUN_EN is defined.
// Ports:
//   clk_i         system clock, posedge
//   rst_i         synchronous reset, active-high
//   signal_i      raw asynchronous inputs, one per channel
//   mode_i        per-channel edge_mode_t, channel n at [2n+1:2n]
//   clear_i       per-channel pending clear strobe
//   level_o       filtered, synchronised levels
//   edge_pulse_o  one-cycle pulse per qualified edge
//   pending_o     sticky event flags
//   irq_o         registered OR of pending_o
//   overrun_o     sticky overrun flags (EDGE_OVERRUN_EN only)
module edge_detector_bank
  import edge_pkg::*;
#(
  parameter int unsigned CHANNELS      = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CHANNELS-1:0]   signal_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   clear_i,
  output logic [CHANNELS-1:0]   level_o,
  output logic [CHANNELS-1:0]   edge_pulse_o,
  output logic [CHANNELS-1:0]   pending_o,
  output logic                  irq_o
`ifdef EDGE_OVERRUN_EN
  ,
  output logic [CHANNELS-1:0]   overrun_o
`endif
);

  // One independent detector per input line.
  for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_chan
    edge_filter_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_chan (
      .clk       (clk_i),
      .rst       (rst_i),
      .signal    (signal_i[n]),
      .mode      (edge_mode_t'(mode_i[2*n +: 2])),
      .clear     (clear_i[n]),
      .level     (level_o[n]),
      .edge_pulse(edge_pulse_o[n]),
      .pending   (pending_o[n])
`ifdef EDGE_OVERRUN_EN
      ,
      .overrun   (overrun_o[n])
`endif
    );
  end

  // Interrupt trails pending_o by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |pending_o;
    end
  end

endmodule

// File: tb/tb_edge_detector_bank.sv
module tb_edge_detector_bank;
  import edge_pkg::*;

  localparam int unsigned CH  = 8;
  localparam int unsigned LAT = 2 + 4 - 1;

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] signal;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clear;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic [CH-1:0] pending;
  logic          irq;
`ifdef EDGE_OVERRUN_EN
  logic [CH-1:0] overrun;
  logic          hi_overrun;
`endif

  logic hi_level, hi_pulse, hi_pending, hi_irq;

  sb_t         sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  edge_detector_bank dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .signal_i    (signal),
    .mode_i      (mode),
    .clear_i     (clear),
    .level_o     (level),
    .edge_pulse_o(pulse),
    .pending_o   (pending),
    .irq_o       (irq)
`ifdef EDGE_OVERRUN_EN
    ,
    .overrun_o   (overrun)
`endif
  );

  // Idle-high single channel: input held at its reset level.
  edge_detector_bank #(.CHANNELS(1), .RESET_LEVEL(1'b1)) dut_hi (
    .clk_i       (clk),
    .rst_i       (rst),
    .signal_i    (1'b1),
    .mode_i      (2'b11),
    .clear_i     (1'b0),
    .level_o     (hi_level),
    .edge_pulse_o(hi_pulse),
    .pending_o   (hi_pending),
    .irq_o       (hi_irq)
`ifdef EDGE_OVERRUN_EN
    ,
    .overrun_o   (hi_overrun)
`endif
  );

  // Advance one clock and pop every pulse the scoreboard expects now.
  task automatic step(output logic [CH-1:0] exp);
    @(posedge clk);
    cyc++;
    #1;
    exp = '0;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        exp[sb[i].ch] = 1'b1;
        sb.delete(i);
      end
    end
  endtask

  task automatic expect_pulse(input int unsigned ch);
    sb.push_back('{cyc + 1 + LAT, ch});
  endtask

  task automatic clear_all();
    logic [CH-1:0] e;
    clear = '1;
    step(e);
    clear = '0;
    step(e);
    step(e);
  endtask

  task automatic test_reset();
    logic [CH-1:0] e;
    rst = 1'b1; signal = '0; mode = '0; clear = '0;
    step(e);
    step(e);
    checks++; if (level !== '0)   begin errors++; $display("FAIL reset_level got=%b exp=%b", level, 8'h00); end
    checks++; if (pulse !== '0)   begin errors++; $display("FAIL reset_pulse got=%b exp=%b", pulse, 8'h00); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got=%b exp=%b", pending, 8'h00); end
    checks++; if (irq !== 1'b0)   begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (hi_level !== 1'b1) begin errors++; $display("FAIL reset_hi_level got=%b exp=1", hi_level); end
`ifdef EDGE_OVERRUN_EN
    checks++; if (overrun !== '0) begin errors++; $display("FAIL reset_overrun got=%b exp=%b", overrun, 8'h00); end
`endif
    rst = 1'b0;
    step(e);
    step(e);
  endtask

  task automatic test_rise_latency();
    logic [CH-1:0] e;
    int unsigned   t;
    mode[1:0] = 2'(EDGE_RISE);
    step(e);
    t = cyc;
    signal[0] = 1'b1;
    expect_pulse(0);
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL rise_pulse cyc=%0d got=%b exp=%b", cyc - t, pulse, e); end
      checks++; if (level[0] !== 1'(cyc >= t + 1 + LAT)) begin errors++; $display("FAIL rise_level cyc=%0d got=%b", cyc - t, level[0]); end
      if (cyc == t + 1 + LAT) begin
        checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL rise_pending got=%b exp=1", pending[0]); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early got=%b exp=0", irq); end
      end
      if (cyc == t + 2 + LAT) begin
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq got=%b exp=1", irq); end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rise_drain left=%0d exp=0", sb.size()); sb.delete(); end
    clear_all();
  endtask

  task automatic test_glitch();
    logic [CH-1:0] e;
    int unsigned   t;
    mode[3:2] = 2'(EDGE_BOTH);
    signal[1] = 1'b1;
    for (int i = 0; i < 3; i++) step(e);
    signal[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL glitch3_pulse got=%b exp=%b", pulse, e); end
      checks++; if (level[1] !== 1'b0) begin errors++; $display("FAIL glitch3_level got=%b exp=0", level[1]); end
    end
    checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL glitch3_pending got=%b exp=0", pending[1]); end
    t = cyc;
    signal[1] = 1'b1;
    expect_pulse(1);
    for (int i = 0; i < 16; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL glitch4_pulse cyc=%0d got=%b exp=%b", cyc - t, pulse, e); end
      if (cyc == t + 4) begin
        signal[1] = 1'b0;
        expect_pulse(1);
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL glitch4_drain left=%0d exp=0", sb.size()); sb.delete(); end
    checks++; if (pending[1] !== 1'b1) begin errors++; $display("FAIL glitch4_pending got=%b exp=1", pending[1]); end
    clear_all();
  endtask

  task automatic test_mode();
    logic [CH-1:0] e;
    mode[5:4] = 2'(EDGE_FALL);
    signal[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL fall_rise_pulse got=%b exp=%b", pulse, e); end
    end
    checks++; if (level[2] !== 1'b1)   begin errors++; $display("FAIL fall_rise_level got=%b exp=1", level[2]); end
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL fall_rise_pending got=%b exp=0", pending[2]); end
    signal[2] = 1'b0;
    expect_pulse(2);
    for (int i = 0; i < 8; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL fall_pulse got=%b exp=%b", pulse, e); end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fall_drain left=%0d exp=0", sb.size()); sb.delete(); end
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL fall_pending got=%b exp=1", pending[2]); end
    clear_all();
    mode[5:4] = 2'(EDGE_OFF);
    for (int i = 0; i < 3; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL off_switch_pulse got=%b exp=%b", pulse, e); end
    end
    signal[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL off_rise_pulse got=%b exp=%b", pulse, e); end
    end
    checks++; if (level[2] !== 1'b1) begin errors++; $display("FAIL off_level got=%b exp=1", level[2]); end
    signal[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL off_fall_pulse got=%b exp=%b", pulse, e); end
    end
    checks++; if (level[2] !== 1'b0)   begin errors++; $display("FAIL off_level_low got=%b exp=0", level[2]); end
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL off_pending got=%b exp=0", pending[2]); end
  endtask

  task automatic test_clear_collision();
    logic [CH-1:0] e;
    int unsigned   t;
    mode[7:6] = 2'(EDGE_BOTH);
    t = cyc;
    signal[3] = 1'b1;
    expect_pulse(3);
    for (int i = 0; i < 16; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL clr_pulse cyc=%0d got=%b exp=%b", cyc - t, pulse, e); end
      if (cyc == t + 6) begin
        checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL clr_first_pending got=%b exp=1", pending[3]); end
        signal[3] = 1'b0;
        expect_pulse(3);
      end
      if (cyc == t + 11) clear[3] = 1'b1;
      if (cyc == t + 12) begin
        checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL clr_collide_pending got=%b exp=1", pending[3]); end
`ifdef EDGE_OVERRUN_EN
        checks++; if (overrun[3] !== 1'b0) begin errors++; $display("FAIL clr_collide_overrun got=%b exp=0", overrun[3]); end
`endif
      end
      if (cyc == t + 13) begin
        clear[3] = 1'b0;
        checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL clr_alone_pending got=%b exp=0", pending[3]); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clr_irq_hold got=%b exp=1", irq); end
      end
      if (cyc == t + 14) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq_drop got=%b exp=0", irq); end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL clr_drain left=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_midcount();
    logic [CH-1:0] e;
    signal[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL rstmid_pre_pulse got=%b exp=%b", pulse, e); end
    end
    rst = 1'b1;
    signal[5] = 1'b1;
    mode[11:10] = 2'(EDGE_RISE);
    step(e);
    checks++; if (level !== '0)   begin errors++; $display("FAIL rstmid_level got=%b exp=%b", level, 8'h00); end
    checks++; if (pulse !== '0)   begin errors++; $display("FAIL rstmid_pulse got=%b exp=%b", pulse, 8'h00); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL rstmid_pending got=%b exp=%b", pending, 8'h00); end
    checks++; if (irq !== 1'b0)   begin errors++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
    rst = 1'b0;
    expect_pulse(5);
    for (int i = 0; i < 12; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL rstmid_post_pulse got=%b exp=%b", pulse, e); end
      checks++; if (hi_pulse !== 1'b0 || hi_level !== 1'b1) begin errors++; $display("FAIL rsthi got pulse=%b level=%b exp pulse=0 level=1", hi_pulse, hi_level); end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rstmid_drain left=%0d exp=0", sb.size()); sb.delete(); end
    checks++; if (level !== 8'h20) begin errors++; $display("FAIL rstmid_final_level got=%b exp=%b", level, 8'h20); end
    clear_all();
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0] e;
    int unsigned   t;
    mode[9:8] = 2'(EDGE_RISE);
    t = cyc;
    signal[4] = 1'b1;
    expect_pulse(4);
    for (int i = 0; i < 20; i++) begin
      step(e);
      checks++; if (pulse !== e) begin errors++; $display("FAIL b2b_pulse cyc=%0d got=%b exp=%b", cyc - t, pulse, e); end
      if (cyc == t + 6) begin
        signal[4] = 1'b0;
`ifdef EDGE_OVERRUN_EN
        checks++; if (overrun[4] !== 1'b0) begin errors++; $display("FAIL b2b_overrun_first got=%b exp=0", overrun[4]); end
`endif
      end
      if (cyc == t + 10) begin
        signal[4] = 1'b1;
        expect_pulse(4);
      end
      if (cyc == t + 16) begin
        checks++; if (pending[4] !== 1'b1) begin errors++; $display("FAIL b2b_pending got=%b exp=1", pending[4]); end
`ifdef EDGE_OVERRUN_EN
        checks++; if (overrun[4] !== 1'b1) begin errors++; $display("FAIL b2b_overrun got=%b exp=1", overrun[4]); end
`endif
        clear[4] = 1'b1;
      end
      if (cyc == t + 17) begin
        clear[4] = 1'b0;
        checks++; if (pending[4] !== 1'b0) begin errors++; $display("FAIL b2b_clear_pending got=%b exp=0", pending[4]); end
`ifdef EDGE_OVERRUN_EN
        checks++; if (overrun[4] !== 1'b0) begin errors++; $display("FAIL b2b_clear_overrun got=%b exp=0", overrun[4]); end
`endif
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain left=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_mode();
    test_clear_collision();
    test_reset_midcount();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
